store_trace_monitor: RTL and testbench

//  Sits downstream of the single-cycle core's data-memory write port and consumes every store it issues.

---
 rtl/store_monitor_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/store_trace_monitor.sv | 93 +++++++++
 tb/tb_store_trace_monitor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/store_monitor_pkg.sv
// rtl/store_monitor_pkg.sv - shared types and default constants for the store trace monitor
package store_monitor_pkg;

    localparam int unsigned TRACE_ADDR_W     = 32;
    localparam int unsigned TRACE_DATA_W     = 32;
    localparam int unsigned DEF_PASS_ADDR    = 100;
    localparam int unsigned DEF_PASS_DATA    = 25;
    localparam int unsigned DEF_SCRATCH_ADDR = 96;

    typedef struct packed {
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } monitor_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with exact occupancy count
module sync_fifo
    import store_monitor_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = trace_entry_t
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  T                           i_data,
    output T                           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    // A push into a full FIFO only lands when a pop frees the head slot in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Head reads as zero when empty so the uninitialised storage never leaks out after reset.
    always_comb begin
        o_data = '0;
        if (!o_empty) begin
            o_data = r_mem[r_rd_ptr];
        end
    end

endmodule

// File: rtl/store_trace_monitor.sv
// rtl/store_trace_monitor.sv - captures core stores into a trace FIFO and derives a sticky pass/fail verdict
module store_trace_monitor
    import store_monitor_pkg::*;
#(
    parameter int unsigned          DEPTH        = 8,
    parameter int unsigned          ADDR_W       = 32,
    parameter int unsigned          DATA_W       = 32,
    parameter logic [ADDR_W-1:0]    PASS_ADDR    = ADDR_W'(DEF_PASS_ADDR),
    parameter logic [DATA_W-1:0]    PASS_DATA    = DATA_W'(DEF_PASS_DATA),
    parameter logic [ADDR_W-1:0]    SCRATCH_ADDR = ADDR_W'(DEF_SCRATCH_ADDR)
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic                       i_writeEnable,
    input  logic [ADDR_W-1:0]          i_rwAddress,
    input  logic [DATA_W-1:0]          i_writeData,
    output logic                       o_traceValid,
    input  logic                       i_traceReady,
    output logic [ADDR_W-1:0]          o_traceAddr,
    output logic [DATA_W-1:0]          o_traceData,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow,
    output logic                       o_pass,
    output logic                       o_fail
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    monitor_state_t r_state;
    monitor_state_t w_state_next;
    logic           r_overflow;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    entry_t         w_entry_in;
    entry_t         w_head;

    // Once a verdict is reached the trace is frozen; only draining continues.
    assign w_push          = i_writeEnable && (r_state == RUN);
    assign w_pop           = i_traceReady;
    assign w_entry_in.addr = i_rwAddress;
    assign w_entry_in.data = i_writeData;

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_data   (w_entry_in),
        .o_data   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (o_count)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state    <= RUN;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == RUN && i_writeEnable) begin
            if (i_rwAddress == PASS_ADDR) begin
                w_state_next = (i_writeData == PASS_DATA) ? PASS : FAIL;
            end else if (i_rwAddress != SCRATCH_ADDR) begin
                w_state_next = FAIL;
            end
        end
    end

    assign o_traceValid = !w_empty;
    assign o_traceAddr  = w_head.addr;
    assign o_traceData  = w_head.data;
    assign o_overflow   = r_overflow;
    assign o_pass       = (r_state == PASS);
    assign o_fail       = (r_state == FAIL);

endmodule

// File: tb/tb_store_trace_monitor.sv
// tb/tb_store_trace_monitor.sv - table-driven bench for store_trace_monitor
module tb_store_trace_monitor;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ready;
    logic        t_valid;
    logic [31:0] t_addr;
    logic [31:0] t_data;
    logic [3:0]  count;
    logic        ovf;
    logic        pass;
    logic        fail;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ready;
        logic        valid;
        logic [31:0] haddr;
        logic [31:0] hdata;
        int          count;
        logic        ovf;
        logic        pass;
        logic        fail;
    } vec_t;

    vec_t vecs[$];

    store_trace_monitor dut (
        .i_clk         (clk),
        .i_arst_n      (rst_n),
        .i_writeEnable (we),
        .i_rwAddress   (addr),
        .i_writeData   (data),
        .o_traceValid  (t_valid),
        .i_traceReady  (ready),
        .o_traceAddr   (t_addr),
        .o_traceData   (t_data),
        .o_count       (count),
        .o_overflow    (ovf),
        .o_pass        (pass),
        .o_fail        (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] ha, input logic [31:0] hd,
                              input int c, input logic o, input logic p, input logic f);
        cmp({tag, " valid"}, 32'(t_valid), 32'(v));
        cmp({tag, " count"}, 32'(count), 32'(c));
        cmp({tag, " overflow"}, 32'(ovf), 32'(o));
        cmp({tag, " pass"}, 32'(pass), 32'(p));
        cmp({tag, " fail"}, 32'(fail), 32'(f));
        if (v) begin
            cmp({tag, " head addr"}, t_addr, ha);
            cmp({tag, " head data"}, t_data, hd);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        we    = 1'b0;
        ready = 1'b0;
        #1;
        expect_out(tag, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cmp({tag, " addr zero"}, t_addr, 32'd0);
        cmp({tag, " data zero"}, t_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
        @(negedge clk);
        we    = w;
        addr  = a;
        data  = d;
        ready = r;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rs, input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic r, input logic v, input logic [31:0] ha, input logic [31:0] hd,
                                input int c, input logic o, input logic p, input logic f);
        vec_t x;
        x.rst = rs; x.we = w; x.addr = a; x.data = d; x.ready = r;
        x.valid = v; x.haddr = ha; x.hdata = hd; x.count = c; x.ovf = o; x.pass = p; x.fail = f;
        return x;
    endfunction

    initial begin
        rst_n = 1'b1;
        we    = 1'b0;
        addr  = '0;
        data  = '0;
        ready = 1'b0;

        // scratch then pass store, drained as they arrive
        vecs.push_back(mk(1, 0,   0,  0, 0, 0,   0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1,  96,  7, 1, 1,  96,  7, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 100, 25, 1, 1, 100, 25, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,   0,  0, 1, 0,   0,  0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 100, 24, 1, 0,   0,  0, 0, 0, 1, 0));
        // wrong pass data then a late correct store
        vecs.push_back(mk(1, 0,   0,  0, 0, 0,   0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 100, 24, 0, 1, 100, 24, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 100, 25, 0, 1, 100, 24, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0,   0,  0, 1, 0,   0,  0, 0, 0, 0, 1));
        // illegal address
        vecs.push_back(mk(1, 0,   0,  0, 0, 0,   0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1,  64, 85, 0, 1,  64, 85, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0,   0,  0, 0, 1,  64, 85, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0,   0,  0, 1, 0,   0,  0, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (vecs[i].rst) begin
                do_reset(tag);
            end else begin
                step(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].ready);
                expect_out(tag, vecs[i].valid, vecs[i].haddr, vecs[i].hdata, vecs[i].count,
                           vecs[i].ovf, vecs[i].pass, vecs[i].fail);
            end
        end

        // nine stores into an 8-deep FIFO with no consumer
        do_reset("ovf rst");
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 32'd96, 32'(i + 1), 1'b0);
            expect_out($sformatf("ovf push%0d", i), 1'b1, 96, 1, (i < 8) ? i + 1 : 8, (i == 8), 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            cmp($sformatf("ovf drain%0d data", i), t_data, 32'(i + 1));
            step(1'b0, 0, 0, 1'b1);
            cmp($sformatf("ovf drain%0d count", i), 32'(count), 32'(7 - i));
        end
        cmp("ovf sticky", 32'(ovf), 32'd1);

        // simultaneous push and pop while full
        do_reset("full rst");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'd96, 32'(i + 1), 1'b0);
        end
        expect_out("full filled", 1'b1, 96, 1, 8, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd96, 32'd100, 1'b1);
        expect_out("full pushpop", 1'b1, 96, 2, 8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cmp($sformatf("full drain%0d data", i), t_data, (i < 7) ? 32'(i + 2) : 32'd100);
            step(1'b0, 0, 0, 1'b1);
        end
        expect_out("full empty", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset in the middle of a drain
        do_reset("async rst0");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'd96, 32'(i + 1), 1'b0);
        end
        step(1'b0, 0, 0, 1'b1);
        expect_out("async draining", 1'b1, 96, 2, 2, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("async mid", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cmp("async addr zero", t_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'd96, 32'h77, 1'b0);
        expect_out("async post", 1'b1, 96, 32'h77, 1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        expect_out("async only", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
